// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the FIFO-draining UART transmitter: the transmit
// state encoding, the frame geometry and the line idle level, plus the
// even-parity helper used when the parity bit is enabled.
// ---------------------------------------------------------------------------
package uart_pkg;

  localparam int   DATA_BITS  = 8;
  localparam logic IDLE_LEVEL = 1'b1;

  // Transmit sequencer states (3-bit encoding).
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ    = 3'd1,
    ST_LATCH  = 3'd2,
    ST_START  = 3'd3,
    ST_DATA   = 3'd4,
    ST_PARITY = 3'd5,
    ST_STOP   = 3'd6
  } uart_state_e;

  // Even parity: the bit that makes the total count of ones even.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// ---------------------------------------------------------------------------
// uart_baud_cnt
// Free-running bit-period counter. Counts 0..CLKS_PER_BIT-1 and wraps.
//   clk       : system clock
//   reset     : asynchronous, active-high reset (count -> 0)
//   clear     : synchronous hold-at-zero while the sequencer is not on a bit
//   tick      : high on the final cycle of a bit period (count == max)
//   tick_next : high when the following cycle will be the final cycle of a
//               bit period; lets the parent register a pulse aligned to tick
// ---------------------------------------------------------------------------
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick,
  output logic tick_next
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: held at zero by clear, otherwise increment and wrap at max.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (cnt_q == CNT_MAX) begin
      cnt_d = {CNT_W{1'b0}};
    end else begin
      cnt_d = cnt_q + CNT_W'(1'b1);
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick      = ~clear & (cnt_q == CNT_MAX);
  assign tick_next = (cnt_d == CNT_MAX);

endmodule

// File: rtl/fifo_uart_tx.sv
// ---------------------------------------------------------------------------
// fifo_uart_tx
// Drains bytes from a synchronous byte FIFO and sends each one as an 8N1
// UART frame (optionally with an even-parity bit before the stop bit).
//   clk            : system clock, rising edge
//   reset          : asynchronous, active-high reset
//   tx_enable      : permits a new byte fetch; an in-flight frame always ends
//   fifo_empty     : FIFO empty flag, looked at only while idle
//   fifo_read_en   : one-cycle pop strobe to the FIFO
//   fifo_read_data : FIFO data, valid the cycle after the pop is sampled
//   tx             : serial line, idle high
//   busy           : high whenever the sequencer is not idle
//   tx_done        : one-cycle pulse on the last cycle of the stop bit
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter bit PARITY_EN    = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_enable,
  input  logic       fifo_empty,
  output logic       fifo_read_en,
  input  logic [7:0] fifo_read_data,
  output logic       tx,
  output logic       busy,
  output logic       tx_done
);

  uart_state_e          state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [2:0]           bit_cnt_q, bit_cnt_d;
  logic                 parity_q, parity_d;
  logic                 tx_q, tx_d;
  logic                 rd_en_q, rd_en_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic baud_clear;
  logic baud_tick;
  logic baud_tick_next;

  // The bit timer only runs while a serial bit is on the line, so every bit
  // period starts from a count of zero.
  assign baud_clear = (state_q == ST_IDLE) || (state_q == ST_REQ) ||
                      (state_q == ST_LATCH);

  uart_baud_cnt #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk       (clk),
    .reset     (reset),
    .clear     (baud_clear),
    .tick      (baud_tick),
    .tick_next (baud_tick_next)
  );

  // Sequencer next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    parity_d  = parity_q;
    tx_d      = tx_q;
    rd_en_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        tx_d = IDLE_LEVEL;
        // The pop is only ever issued against a non-empty FIFO.
        if (tx_enable && !fifo_empty) begin
          state_d = ST_REQ;
          rd_en_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_REQ: begin
        // FIFO samples the pop at this edge; its data is valid next cycle.
        state_d = ST_LATCH;
      end

      ST_LATCH: begin
        shift_d   = fifo_read_data;
        parity_d  = even_parity(fifo_read_data);
        bit_cnt_d = 3'd0;
        tx_d      = 1'b0;
        state_d   = ST_START;
      end

      ST_START: begin
        if (baud_tick) begin
          state_d   = ST_DATA;
          bit_cnt_d = 3'd0;
          tx_d      = shift_q[0];
        end else begin
          state_d = ST_START;
        end
      end

      ST_DATA: begin
        if (baud_tick) begin
          if (bit_cnt_q == 3'(DATA_BITS - 1)) begin
            bit_cnt_d = 3'd0;
            if (PARITY_EN) begin
              state_d = ST_PARITY;
              tx_d    = parity_q;
            end else begin
              state_d = ST_STOP;
              tx_d    = IDLE_LEVEL;
            end
          end else begin
            // LSB first: the next bit is always at position 1 before shifting.
            bit_cnt_d = bit_cnt_q + 3'd1;
            shift_d   = {1'b0, shift_q[DATA_BITS-1:1]};
            tx_d      = shift_q[1];
          end
        end else begin
          state_d = ST_DATA;
        end
      end

      ST_PARITY: begin
        if (baud_tick) begin
          state_d = ST_STOP;
          tx_d    = IDLE_LEVEL;
        end else begin
          state_d = ST_PARITY;
        end
      end

      ST_STOP: begin
        tx_d = IDLE_LEVEL;
        if (baud_tick) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_STOP;
        end
      end

      default: begin
        state_d   = ST_IDLE;
        bit_cnt_d = 3'd0;
        tx_d      = IDLE_LEVEL;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
    // Registered so it lands on the stop bit's final cycle, the same cycle
    // in which the bit timer reaches terminal count.
    done_d = (state_d == ST_STOP) && baud_tick_next;
  end

  // Sequencer and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      shift_q   <= {DATA_BITS{1'b0}};
      bit_cnt_q <= 3'd0;
      parity_q  <= 1'b0;
      tx_q      <= IDLE_LEVEL;
      rd_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      parity_q  <= parity_d;
      tx_q      <= tx_d;
      rd_en_q   <= rd_en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign tx           = tx_q;
  assign fifo_read_en = rd_en_q;
  assign busy         = busy_q;
  assign tx_done      = done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_fifo_uart_tx
// Two transmitters (no parity / even parity) at 4 clocks per bit, each fed
// by a small FIFO model. A line monitor decodes frames; the main process
// compares decoded frames against an expected-byte queue.
// ---------------------------------------------------------------------------
module tb_fifo_uart_tx;

  localparam int CPB = 4;

  typedef struct packed {
    logic [7:0] data;
    logic       par;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    logic       start;
    logic       par;
    logic       stop;
    logic       steady;
    logic       done_ok;
    logic       busy_ok;
    int         gap;
    logic       aborted;
  } rx_t;

  typedef struct {
    int         grp;
    int         inst;
    logic [7:0] data;
    logic       exp_par;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst0, rst1, en0, en1;
  logic       empty0, empty1;
  logic [7:0] rdata0 = 8'h00;
  logic [7:0] rdata1 = 8'h00;
  logic       rd0, rd1, tx0, tx1, busy0, busy1, done0, done1;

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b0)) dut0 (
    .clk(clk), .reset(rst0), .tx_enable(en0), .fifo_empty(empty0),
    .fifo_read_en(rd0), .fifo_read_data(rdata0), .tx(tx0), .busy(busy0),
    .tx_done(done0)
  );

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b1)) dut1 (
    .clk(clk), .reset(rst1), .tx_enable(en1), .fifo_empty(empty1),
    .fifo_read_en(rd1), .fifo_read_data(rdata1), .tx(tx1), .busy(busy1),
    .tx_done(done1)
  );

  // FIFO models: registered read, data appears at the edge sampling the pop.
  logic [7:0] mem0 [0:63];
  logic [7:0] mem1 [0:63];
  int pushed0 = 0, popped0 = 0, rd_cnt0 = 0, uflow0 = 0;
  int pushed1 = 0, popped1 = 0, rd_cnt1 = 0, uflow1 = 0;

  assign empty0 = (pushed0 == popped0);
  assign empty1 = (pushed1 == popped1);

  // Pop handling for both FIFO models.
  always @(posedge clk) begin
    if (rd0) begin
      rd_cnt0 <= rd_cnt0 + 1;
      if (popped0 < pushed0) begin
        rdata0  <= mem0[popped0];
        popped0 <= popped0 + 1;
      end else begin
        uflow0 <= uflow0 + 1;
      end
    end
    if (rd1) begin
      rd_cnt1 <= rd_cnt1 + 1;
      if (popped1 < pushed1) begin
        rdata1  <= mem1[popped1];
        popped1 <= popped1 + 1;
      end else begin
        uflow1 <= uflow1 + 1;
      end
    end
  end

  // Line monitor state (written only by the monitor process).
  rx_t         rx0[$];
  rx_t         rx1[$];
  logic        m_in[2];
  int          m_bit[2], m_cyc[2], m_gap[2], m_sgap[2], m_stray[2];
  logic [10:0] m_bits[2];
  logic        m_steady[2], m_dok[2], m_bok[2];

  // Decode frames cycle by cycle, checking every cycle of every bit.
  initial begin
    rx_t  e;
    logic t, dn, bz, rs;
    int   nb;
    for (int i = 0; i < 2; i++) begin
      m_in[i] = 1'b0; m_bit[i] = 0; m_cyc[i] = 0; m_gap[i] = 0;
      m_sgap[i] = 0; m_stray[i] = 0; m_bits[i] = 11'd0;
      m_steady[i] = 1'b1; m_dok[i] = 1'b1; m_bok[i] = 1'b1;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        t  = (i == 0) ? tx0 : tx1;
        dn = (i == 0) ? done0 : done1;
        bz = (i == 0) ? busy0 : busy1;
        rs = (i == 0) ? rst0 : rst1;
        nb = (i == 0) ? 10 : 11;
        if (rs) begin
          if (m_in[i]) begin
            e = '{data: 8'h00, start: 1'b0, par: 1'b0, stop: 1'b0, steady: 1'b0,
                  done_ok: 1'b0, busy_ok: 1'b0, gap: 0, aborted: 1'b1};
            if (i == 0) rx0.push_back(e); else rx1.push_back(e);
          end
          m_in[i]  = 1'b0;
          m_gap[i] = 0;
        end else begin
          if (!m_in[i]) begin
            if (t === 1'b0) begin
              m_in[i] = 1'b1; m_bit[i] = 0; m_cyc[i] = 0; m_bits[i] = 11'd0;
              m_steady[i] = 1'b1; m_dok[i] = 1'b1; m_bok[i] = 1'b1;
              m_sgap[i] = m_gap[i];
            end else begin
              m_gap[i]++;
              if (dn !== 1'b0) m_stray[i]++;
            end
          end
          if (m_in[i]) begin
            if (m_cyc[i] == 0) m_bits[i][m_bit[i]] = t;
            else if (t !== m_bits[i][m_bit[i]]) m_steady[i] = 1'b0;
            if (dn !== ((m_bit[i] == nb - 1) && (m_cyc[i] == CPB - 1))) m_dok[i] = 1'b0;
            if (bz !== 1'b1) m_bok[i] = 1'b0;
            m_cyc[i]++;
            if (m_cyc[i] == CPB) begin
              m_cyc[i] = 0;
              m_bit[i]++;
              if (m_bit[i] == nb) begin
                e = '{data: m_bits[i][8:1], start: m_bits[i][0],
                      par: (nb == 11) ? m_bits[i][9] : 1'b0,
                      stop: m_bits[i][nb-1], steady: m_steady[i],
                      done_ok: m_dok[i], busy_ok: m_bok[i],
                      gap: m_sgap[i], aborted: 1'b0};
                if (i == 0) rx0.push_back(e); else rx1.push_back(e);
                m_in[i]  = 1'b0;
                m_gap[i] = 0;
              end
            end
          end
        end
      end
    end
  end

  // Scoreboard and checking (main process only).
  int   checks = 0;
  int   failures = 0;
  exp_t exp0[$];
  exp_t exp1[$];
  int   ri[2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got %0h, want %0h", name, act, want);
    end
  endtask

  task automatic push(input int inst, input logic [7:0] d, input logic p);
    if (inst == 0) begin
      mem0[pushed0] = d; pushed0++; exp0.push_back('{data: d, par: p});
    end else begin
      mem1[pushed1] = d; pushed1++; exp1.push_back('{data: d, par: p});
    end
  endtask

  function automatic int rxsz(input int inst);
    return (inst == 0) ? rx0.size() : rx1.size();
  endfunction

  task automatic wait_rx(input int inst, input int n);
    int k;
    k = 0;
    while (rxsz(inst) < ri[inst] + n && k < 200 * n) begin
      @(negedge clk);
      k++;
    end
    if (rxsz(inst) < ri[inst] + n) check($sformatf("rx_timeout%0d", inst), rxsz(inst), ri[inst] + n);
  endtask

  task automatic next_pair(input int inst, output rx_t r, output exp_t e, output bit ok);
    ok = 1'b0;
    if (rxsz(inst) > ri[inst]) begin
      r = (inst == 0) ? rx0[ri[inst]] : rx1[ri[inst]];
      ri[inst]++;
      if ((inst == 0 ? exp0.size() : exp1.size()) == 0) begin
        check($sformatf("unexpected_frame%0d", inst), 1, 0);
      end else begin
        e  = (inst == 0) ? exp0.pop_front() : exp1.pop_front();
        ok = 1'b1;
      end
    end
  endtask

  task automatic compare_frames(input int inst, input int n);
    rx_t  r;
    exp_t e;
    bit   ok;
    wait_rx(inst, n);
    for (int j = 0; j < n; j++) begin
      next_pair(inst, r, e, ok);
      if (ok) begin
        check($sformatf("data%0d", inst), r.data, e.data);
        if (inst == 1) check("parity1", r.par, e.par);
        check($sformatf("framing%0d", inst), {r.aborted, r.start, r.stop, r.steady}, 4'b0011);
        check($sformatf("tx_done%0d", inst), r.done_ok, 1'b1);
        check($sformatf("busy_in_frame%0d", inst), r.busy_ok, 1'b1);
        if (j > 0) check($sformatf("gap%0d", inst), r.gap, 3);
      end
    end
  endtask

  task automatic wait_rd0();
    int k;
    k = 0;
    while (rd0 !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("rd_seen0", rd0, 1'b1);
  endtask

  initial begin
    vec_t vecs[6];
    int   inst, n, rd_before, bad;
    rx_t  r;
    exp_t e;
    bit   ok;

    vecs[0] = '{grp: 1, inst: 0, data: 8'hA5, exp_par: 1'b0};
    vecs[1] = '{grp: 2, inst: 1, data: 8'hA5, exp_par: 1'b0};
    vecs[2] = '{grp: 2, inst: 1, data: 8'h07, exp_par: 1'b1};
    vecs[3] = '{grp: 3, inst: 0, data: 8'h00, exp_par: 1'b0};
    vecs[4] = '{grp: 3, inst: 0, data: 8'hFF, exp_par: 1'b0};
    vecs[5] = '{grp: 3, inst: 0, data: 8'h3C, exp_par: 1'b0};
    ri[0] = 0;
    ri[1] = 0;

    rst0 = 1'b1; rst1 = 1'b1; en0 = 1'b0; en1 = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_tx0", tx0, 1'b1);
    check("reset_busy0", busy0, 1'b0);
    check("reset_done0", done0, 1'b0);
    check("reset_rd0", rd0, 1'b0);
    check("reset_tx1", tx1, 1'b1);
    check("reset_busy1", busy1, 1'b0);
    rst0 = 1'b0; rst1 = 1'b0;
    repeat (2) @(negedge clk);

    // Table-driven groups: single byte, parity pair, back-to-back triple.
    for (int g = 1; g <= 3; g++) begin
      inst = 0;
      n    = 0;
      for (int v = 0; v < 6; v++) begin
        if (vecs[v].grp == g) begin
          push(vecs[v].inst, vecs[v].data, vecs[v].exp_par);
          inst = vecs[v].inst;
          n++;
        end
      end
      rd_before = (inst == 0) ? rd_cnt0 : rd_cnt1;
      if (inst == 0) en0 = 1'b1; else en1 = 1'b1;
      compare_frames(inst, n);
      repeat (3 * CPB) @(negedge clk);
      check($sformatf("rd_pulses_g%0d", g), ((inst == 0) ? rd_cnt0 : rd_cnt1) - rd_before, n);
      check($sformatf("busy_after_g%0d", g), (inst == 0) ? busy0 : busy1, 1'b0);
      check($sformatf("tx_idle_g%0d", g), (inst == 0) ? tx0 : tx1, 1'b1);
      check($sformatf("empty_g%0d", g), (inst == 0) ? empty0 : empty1, 1'b1);
      en0 = 1'b0;
      en1 = 1'b0;
    end

    // Empty FIFO with enable high, then data present with enable low.
    en0 = 1'b1;
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (rd0 !== 1'b0 || tx0 !== 1'b1 || busy0 !== 1'b0) bad++;
    end
    check("empty_gate", bad, 0);
    en0 = 1'b0;
    push(0, 8'h5A, 1'b0);
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (rd0 !== 1'b0 || tx0 !== 1'b1 || busy0 !== 1'b0) bad++;
    end
    check("enable_gate", bad, 0);
    en0 = 1'b1;
    @(negedge clk);
    check("fetch_latency", rd0, 1'b1);
    compare_frames(0, 1);

    // Enable dropped mid-frame: frame finishes, second byte stays queued.
    push(0, 8'h96, 1'b0);
    push(0, 8'h69, 1'b0);
    rd_before = rd_cnt0;
    wait_rd0();
    repeat (10) @(negedge clk);
    en0 = 1'b0;
    compare_frames(0, 1);
    repeat (30) @(negedge clk);
    check("rd_after_disable", rd_cnt0 - rd_before, 1);
    check("fifo_left", pushed0 - popped0, 1);

    // Reset during data bit 3 of the next frame.
    en0 = 1'b1;
    wait_rd0();
    repeat (19) @(negedge clk);
    #2 rst0 = 1'b1;
    #1;
    check("rst_tx", tx0, 1'b1);
    check("rst_busy", busy0, 1'b0);
    check("rst_rd", rd0, 1'b0);
    @(negedge clk);
    wait_rx(0, 1);
    next_pair(0, r, e, ok);
    if (ok) check("aborted_frame", r.aborted, 1'b1);
    @(negedge clk);
    rst0 = 1'b0;
    push(0, 8'hC3, 1'b0);
    compare_frames(0, 1);
    repeat (3 * CPB) @(negedge clk);
    check("rd_after_reset", rd_cnt0 - rd_before, 3);
    check("fifo_drained", pushed0 - popped0, 0);
    check("stray_done0", m_stray[0], 0);
    check("stray_done1", m_stray[1], 0);
    check("underflow", uflow0 + uflow1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
